frequency_meter: RTL and testbench

Measures an external or divided clock-like signal against the system clock.
- Counts rising edges of an asynchronous input over a fixed gate window of system-clock cycles (frequency mode).
- Also measures the most recent full input period in system-clock cycles (period mode).
- Receive-side checker for divided clocks generated in the SoC.
- Used for on-board clock monitoring and self-test. Results are exposed to a CSR wrapper.

---
 rtl/frequency_meter_if.sv | 22 ++
 rtl/frequency_meter.sv | 143 ++++++++++++++
 tb/tb_frequency_meter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frequency_meter_if.sv
// Result bundle from the frequency meter towards its CSR wrapper.
// The meter drives every field; the CSR side only observes.
interface frequency_meter_if #(
  parameter int COUNT_WIDTH = 16
);
  logic [COUNT_WIDTH-1:0] measuredCount;
  logic                   measureValid;
  logic                   countOverflow;
  logic [COUNT_WIDTH-1:0] lastPeriod;
  logic                   periodValid;
  logic                   periodOverflow;

  modport master (
    output measuredCount, measureValid, countOverflow,
    output lastPeriod, periodValid, periodOverflow
  );

  modport slave (
    input measuredCount, measureValid, countOverflow,
    input lastPeriod, periodValid, periodOverflow
  );
endinterface

// File: rtl/frequency_meter.sv
// Frequency meter: counts synchronized rising edges of signalIn per gate window
// and measures the spacing of the last two edges, both in inputCLK cycles.
module frequency_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int GATE_WIDTH  = 10,
  parameter int COUNT_WIDTH = 16
) (
  input  logic              inputCLK,
  input  logic              reset,
  input  logic              signalIn,
  frequency_meter_if.master res_o
);

  localparam logic [GATE_WIDTH-1:0]  GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);

  logic                   s1_q, s2_q, s3_q;
  logic                   edge_s, win_end_s;
  logic [GATE_WIDTH-1:0]  gate_q, gate_d;
  logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d, cnt_inc_s;
  logic                   edge_sat_q, edge_sat_d, sat_inc_s;
  logic [COUNT_WIDTH-1:0] measured_q, measured_d;
  logic                   mvalid_q, mvalid_d;
  logic                   covf_q, covf_d;
  logic [COUNT_WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic                   per_sat_q, per_sat_d;
  logic                   armed_q, armed_d;
  logic [COUNT_WIDTH-1:0] last_period_q, last_period_d;
  logic                   pvalid_q, pvalid_d;
  logic                   povf_q, povf_d;

  // Two-flop synchronizer plus history flop for rising-edge detection.
  always_ff @(posedge inputCLK or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= signalIn;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_s    = s2_q & ~s3_q;
  assign win_end_s = (gate_q == GATE_LAST);

  // Next-state logic for the gate, edge-count and period paths.
  always_comb begin
    gate_d        = win_end_s ? {GATE_WIDTH{1'b0}} : gate_q + GATE_WIDTH'(1);
    measured_d    = measured_q;
    covf_d        = covf_q;
    mvalid_d      = 1'b0;
    last_period_d = last_period_q;
    povf_d        = povf_q;
    pvalid_d      = 1'b0;
    armed_d       = armed_q;

    if (edge_s) begin
      if (edge_cnt_q == CNT_MAX) begin
        cnt_inc_s = edge_cnt_q;
        sat_inc_s = 1'b1;
      end else begin
        cnt_inc_s = edge_cnt_q + CNT_ONE;
        sat_inc_s = edge_sat_q;
      end
    end else begin
      cnt_inc_s = edge_cnt_q;
      sat_inc_s = edge_sat_q;
    end

    // The window-end edge is already folded into cnt_inc_s, so it closes with this window.
    if (win_end_s) begin
      measured_d = cnt_inc_s;
      covf_d     = sat_inc_s;
      mvalid_d   = 1'b1;
      edge_cnt_d = {COUNT_WIDTH{1'b0}};
      edge_sat_d = 1'b0;
    end else begin
      edge_cnt_d = cnt_inc_s;
      edge_sat_d = sat_inc_s;
    end

    if (edge_s) begin
      period_cnt_d = CNT_ONE;
      per_sat_d    = 1'b0;
      armed_d      = 1'b1;
      if (armed_q) begin
        last_period_d = period_cnt_q;
        povf_d        = per_sat_q;
        pvalid_d      = 1'b1;
      end else begin
        last_period_d = last_period_q;
      end
    end else if (period_cnt_q == CNT_MAX) begin
      period_cnt_d = period_cnt_q;
      per_sat_d    = 1'b1;
    end else begin
      period_cnt_d = period_cnt_q + CNT_ONE;
      per_sat_d    = per_sat_q;
    end
  end

  // State and result registers.
  always_ff @(posedge inputCLK or posedge reset) begin
    if (reset) begin
      gate_q        <= {GATE_WIDTH{1'b0}};
      edge_cnt_q    <= {COUNT_WIDTH{1'b0}};
      edge_sat_q    <= 1'b0;
      measured_q    <= {COUNT_WIDTH{1'b0}};
      mvalid_q      <= 1'b0;
      covf_q        <= 1'b0;
      period_cnt_q  <= {COUNT_WIDTH{1'b0}};
      per_sat_q     <= 1'b0;
      armed_q       <= 1'b0;
      last_period_q <= {COUNT_WIDTH{1'b0}};
      pvalid_q      <= 1'b0;
      povf_q        <= 1'b0;
    end else begin
      gate_q        <= gate_d;
      edge_cnt_q    <= edge_cnt_d;
      edge_sat_q    <= edge_sat_d;
      measured_q    <= measured_d;
      mvalid_q      <= mvalid_d;
      covf_q        <= covf_d;
      period_cnt_q  <= period_cnt_d;
      per_sat_q     <= per_sat_d;
      armed_q       <= armed_d;
      last_period_q <= last_period_d;
      pvalid_q      <= pvalid_d;
      povf_q        <= povf_d;
    end
  end

  assign res_o.measuredCount  = measured_q;
  assign res_o.measureValid   = mvalid_q;
  assign res_o.countOverflow  = covf_q;
  assign res_o.lastPeriod     = last_period_q;
  assign res_o.periodValid    = pvalid_q;
  assign res_o.periodOverflow = povf_q;

endmodule

// File: tb/tb_frequency_meter.sv
// Bench for frequency_meter: three instances (different gate/count sizes) share one
// input; a timestamp-based reference model plus directed tables check all outputs.
module tb_frequency_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signalIn = 1'b0;

  always #5 clk = ~clk;

  frequency_meter_if #(.COUNT_WIDTH(16)) if_a ();
  frequency_meter_if #(.COUNT_WIDTH(16)) if_b ();
  frequency_meter_if #(.COUNT_WIDTH(4))  if_c ();

  frequency_meter #(.GATE_CYCLES(20),  .GATE_WIDTH(5), .COUNT_WIDTH(16)) dut_a (
    .inputCLK(clk), .reset(rst), .signalIn(signalIn), .res_o(if_a));
  frequency_meter #(.GATE_CYCLES(100), .GATE_WIDTH(7), .COUNT_WIDTH(16)) dut_b (
    .inputCLK(clk), .reset(rst), .signalIn(signalIn), .res_o(if_b));
  frequency_meter #(.GATE_CYCLES(100), .GATE_WIDTH(7), .COUNT_WIDTH(4))  dut_c (
    .inputCLK(clk), .reset(rst), .signalIn(signalIn), .res_o(if_c));

  int nchecks = 0;
  int nerr    = 0;

  // reference model: cycle timestamps since reset release
  int gc[3] = '{20, 100, 100};
  int mx[3] = '{65535, 65535, 15};
  string nm[3] = '{"a", "b", "c"};
  int   q;
  logic hist[$];
  int   cnt[3], last_e[3], e_mc[3], e_lp[3];
  bit   armed[3], e_mv[3], e_co[3], e_pv[3], e_po[3];

  typedef struct {
    int   gap;
    int   exp_lp;
    logic exp_po;
  } per_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d (%h) expected %0d", name, act, act, exp);
    end
  endtask

  function automatic bit samp(input int p);
    if (p < 1) return 1'b0;
    return hist[p-1] === 1'b1;
  endfunction

  task automatic model_reset();
    q = 0;
    hist.delete();
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0; last_e[i] = 0; armed[i] = 0;
      e_mc[i] = 0; e_lp[i] = 0; e_mv[i] = 0; e_co[i] = 0; e_pv[i] = 0; e_po[i] = 0;
    end
  endtask

  task automatic model_update();
    bit ed;
    int n;
    q++;
    hist.push_back(signalIn);
    ed = samp(q - 2) && !samp(q - 3);
    for (int i = 0; i < 3; i++) begin
      e_mv[i] = 0;
      e_pv[i] = 0;
      if (ed) begin
        cnt[i]++;
        if (armed[i]) begin
          n = q - last_e[i];
          e_lp[i] = (n > mx[i]) ? mx[i] : n;
          e_po[i] = (n > mx[i]);
          e_pv[i] = 1;
        end
        armed[i]  = 1;
        last_e[i] = q;
      end
      if (q % gc[i] == 0) begin
        e_mc[i] = (cnt[i] > mx[i]) ? mx[i] : cnt[i];
        e_co[i] = (cnt[i] > mx[i]);
        e_mv[i] = 1;
        cnt[i]  = 0;
      end
    end
  endtask

  task automatic get_act(input int i, output logic [31:0] mc, output logic [31:0] lp,
                         output logic mv, output logic co, output logic pv, output logic po);
    case (i)
      0: begin
        mc = 32'(if_a.measuredCount); lp = 32'(if_a.lastPeriod);
        mv = if_a.measureValid; co = if_a.countOverflow; pv = if_a.periodValid; po = if_a.periodOverflow;
      end
      1: begin
        mc = 32'(if_b.measuredCount); lp = 32'(if_b.lastPeriod);
        mv = if_b.measureValid; co = if_b.countOverflow; pv = if_b.periodValid; po = if_b.periodOverflow;
      end
      default: begin
        mc = 32'(if_c.measuredCount); lp = 32'(if_c.lastPeriod);
        mv = if_c.measureValid; co = if_c.countOverflow; pv = if_c.periodValid; po = if_c.periodOverflow;
      end
    endcase
  endtask

  task automatic model_check();
    logic [31:0] mc, lp;
    logic mv, co, pv, po;
    for (int i = 0; i < 3; i++) begin
      get_act(i, mc, lp, mv, co, pv, po);
      chk($sformatf("%s.measuredCount@%0d", nm[i], q), mc, 32'(e_mc[i]));
      chk($sformatf("%s.measureValid@%0d", nm[i], q), 32'(mv), 32'(e_mv[i]));
      chk($sformatf("%s.countOverflow@%0d", nm[i], q), 32'(co), 32'(e_co[i]));
      chk($sformatf("%s.lastPeriod@%0d", nm[i], q), lp, 32'(e_lp[i]));
      chk($sformatf("%s.periodValid@%0d", nm[i], q), 32'(pv), 32'(e_pv[i]));
      chk($sformatf("%s.periodOverflow@%0d", nm[i], q), 32'(po), 32'(e_po[i]));
    end
  endtask

  // drive value for the next posedge, then compare at the following negedge
  task automatic step(input logic v);
    signalIn = v;
    @(posedge clk);
    model_update();
    @(negedge clk);
    model_check();
  endtask

  // same, but with an intra-cycle glitch before settling
  task automatic step_async(input logic v);
    signalIn = 1'($urandom_range(0, 1));
    #($urandom_range(1, 3));
    signalIn = v;
    @(posedge clk);
    model_update();
    @(negedge clk);
    model_check();
  endtask

  task automatic do_reset();
    logic [31:0] mc, lp;
    logic mv, co, pv, po;
    @(posedge clk);
    #2;
    rst = 1'b1;
    signalIn = ~signalIn;
    #1;
    for (int i = 0; i < 3; i++) begin
      get_act(i, mc, lp, mv, co, pv, po);
      chk($sformatf("rst_%s_mc", nm[i]), mc, 32'd0);
      chk($sformatf("rst_%s_lp", nm[i]), lp, 32'd0);
      chk($sformatf("rst_%s_flags", nm[i]), 32'({mv, co, pv, po}), 32'd0);
    end
    repeat (3) begin
      @(negedge clk);
      signalIn = ~signalIn;
    end
    @(negedge clk);
    rst = 1'b0;
    signalIn = 1'b0;
    model_reset();
  endtask

  initial begin
    per_vec_t ptab[6];
    logic cur;
    int density;
    int first_mv;

    ptab[0] = '{gap: 40, exp_lp: 15, exp_po: 1'b1};
    ptab[1] = '{gap: 7,  exp_lp: 7,  exp_po: 1'b0};
    ptab[2] = '{gap: 15, exp_lp: 15, exp_po: 1'b0};
    ptab[3] = '{gap: 16, exp_lp: 15, exp_po: 1'b1};
    ptab[4] = '{gap: 3,  exp_lp: 3,  exp_po: 1'b0};
    ptab[5] = '{gap: 2,  exp_lp: 2,  exp_po: 1'b0};

    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // window-end edge on dut_a: rise sampled at cycle 18 becomes edge on gate==19
    for (int n = 1; n <= 40; n++) begin
      step((n >= 18 && n <= 25) ? 1'b1 : 1'b0);
      if (n == 20) begin
        chk("winend_mv", 32'(if_a.measureValid), 32'd1);
        chk("winend_mc", 32'(if_a.measuredCount), 32'd1);
      end
      if (n == 40) begin
        chk("winend_next_mc", 32'(if_a.measuredCount), 32'd0);
      end
    end

    // divide-by-10 input
    do_reset();
    for (int n = 1; n <= 300; n++) begin
      step(((n - 1) % 10) < 5 ? 1'b1 : 1'b0);
      if (n == 100 || n == 200) begin
        chk("div10_mc", 32'(if_b.measuredCount), 32'd10);
        chk("div10_co", 32'(if_b.countOverflow), 32'd0);
        chk("div10_lp", 32'(if_b.lastPeriod), 32'd10);
      end
    end

    // saturating edge counter, then a static window
    do_reset();
    for (int n = 1; n <= 200; n++) begin
      step((n <= 100 && ((n - 1) % 4) < 2) ? 1'b1 : 1'b0);
      if (n == 100) begin
        chk("sat_mc", 32'(if_c.measuredCount), 32'd15);
        chk("sat_co", 32'(if_c.countOverflow), 32'd1);
        chk("sat_b_mc", 32'(if_b.measuredCount), 32'd25);
      end
      if (n == 200) begin
        chk("sat_next_mv", 32'(if_c.measureValid), 32'd1);
        chk("sat_next_mc", 32'(if_c.measuredCount), 32'd0);
        chk("sat_next_co", 32'(if_c.countOverflow), 32'd0);
      end
    end

    // first window after release is full length
    do_reset();
    first_mv = -1;
    for (int n = 1; n <= 150 && first_mv < 0; n++) begin
      step(1'($urandom_range(0, 1)));
      if (if_b.measureValid === 1'b1) first_mv = n;
    end
    chk("first_mv_cycle", 32'(first_mv), 32'd100);

    // period table on the 4-bit instance
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(1'b1);
      for (int j = 0; j < ptab[k].gap - 1; j++) step(1'b0);
      step(1'b1);
      step(1'b0);
      step(1'b0);
      chk($sformatf("ptab%0d_pv", k), 32'(if_c.periodValid), 32'd1);
      chk($sformatf("ptab%0d_lp", k), 32'(if_c.lastPeriod), 32'(ptab[k].exp_lp));
      chk($sformatf("ptab%0d_po", k), 32'(if_c.periodOverflow), 32'(ptab[k].exp_po));
      step(1'b0);
      step(1'b0);
    end

    // randomized asynchronous-looking stimulus with varying edge density
    cur = 1'b0;
    density = 1;
    for (int n = 0; n < 1600; n++) begin
      if (n % 200 == 0) density = $urandom_range(1, 24);
      if (n == 900) begin
        do_reset();
        cur = 1'b0;
      end
      if ($urandom_range(0, density - 1) == 0) cur = ~cur;
      step_async(cur);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
